// File: rtl/shift_alu_datapath.sv
// Multi-cycle register-file datapath: a valid/ready instruction is taken in IDLE,
// then it runs through FETCH, EXEC (SHLN takes one cycle per bit) and WB.
module shift_alu_datapath #(
  parameter int WIDTH = 8,
  parameter int NREG = 4,
  localparam int RW = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [RW-1:0]    rd,
  input  logic [RW-1:0]    rs,
  input  logic [WIDTH-1:0] imm,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic [WIDTH-1:0] out,
  input  logic [RW-1:0]    dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] N_MAX = CW'(WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_WB    = 2'd3;

  localparam logic [2:0] OP_LDI  = 3'd0;
  localparam logic [2:0] OP_MOV  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_ADD  = 3'd4;
  localparam logic [2:0] OP_SHL  = 3'd5;
  localparam logic [2:0] OP_SHLN = 3'd6;
  localparam logic [2:0] OP_NOP  = 3'd7;

  logic [1:0]       state;
  logic [WIDTH-1:0] regs [NREG];
  logic [2:0]       op_q;
  logic [RW-1:0]    rd_q;
  logic [RW-1:0]    rs_q;
  logic [WIDTH-1:0] imm_q;
  logic [WIDTH-1:0] tmp;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt;
  logic             sh_carry;
  logic [WIDTH-1:0] result_q;
  logic [CW-1:0]    n_amt;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] wb_val;
  logic             wb_carry;
  logic             wb_write;

  // Handshake: a transfer happens on a rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE and never while reset_n is low.
  assign in_ready = (state == S_IDLE) && reset_n;
  assign done     = (state == S_WB);
  assign wb_write = (state == S_WB) && (op_q != OP_NOP);
  assign result   = wb_write ? wb_val : result_q;
  assign out      = regs[0];
  assign dbg_data = regs[dbg_sel];

  // Shift amount saturates at WIDTH so the counter never needs more than CW bits.
  assign n_amt = (imm_q > WIDTH'(WIDTH)) ? N_MAX : imm_q[CW-1:0];
  assign sum   = {1'b0, tmp} + {1'b0, b_q};

  always_comb begin
    wb_val   = tmp;
    wb_carry = 1'b0;
    case (op_q)
      OP_LDI:  wb_val = imm_q;
      OP_MOV:  wb_val = b_q;
      OP_XOR:  wb_val = tmp ^ b_q;
      OP_AND:  wb_val = tmp & b_q;
      OP_ADD:  begin
        wb_val   = sum[WIDTH-1:0];
        wb_carry = sum[WIDTH];
      end
      OP_SHL:  begin
        wb_val   = b_q << 1;
        wb_carry = b_q[WIDTH-1];
      end
      OP_SHLN: begin
        wb_val   = tmp;
        wb_carry = sh_carry;
      end
      default: wb_val = tmp;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      op_q     <= OP_NOP;
      rd_q     <= '0;
      rs_q     <= '0;
      imm_q    <= '0;
      tmp      <= '0;
      b_q      <= '0;
      cnt      <= '0;
      sh_carry <= 1'b0;
      result_q <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q  <= opcode;
            rd_q  <= rd;
            rs_q  <= rs;
            imm_q <= imm;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          tmp      <= regs[rd_q];
          b_q      <= regs[rs_q];
          cnt      <= n_amt;
          sh_carry <= 1'b0;
          state    <= S_EXEC;
        end
        S_EXEC: begin
          // SHLN stays here max(n,1) cycles, shifting one bit per cycle.
          if ((op_q == OP_SHLN) && (cnt != '0)) begin
            tmp      <= tmp << 1;
            sh_carry <= tmp[WIDTH-1];
            cnt      <= cnt - CW'(1);
          end
          if ((op_q != OP_SHLN) || (cnt <= CW'(1))) state <= S_WB;
        end
        default: begin
          if (op_q != OP_NOP) begin
            regs[rd_q] <= wb_val;
            result_q   <= wb_val;
            zero       <= (wb_val == '0);
            carry      <= wb_carry;
          end
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_alu_datapath.sv
// Bench for shift_alu_datapath: scoreboard-checked default instance (8x4) plus a
// directed run on a 16-bit, 8-register instance.
module tb_shift_alu_datapath;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int RW = 2;
  localparam int W2 = 16;
  localparam int N2 = 8;
  localparam int RW2 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  // ---------------- default instance ----------------
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    opcode = 3'd0;
  logic [RW-1:0] rd = '0;
  logic [RW-1:0] rs = '0;
  logic [W-1:0]  imm = '0;
  logic          done;
  logic [W-1:0]  result;
  logic          zero;
  logic          carry;
  logic [W-1:0]  out;
  logic [RW-1:0] dbg_sel = '0;
  logic [W-1:0]  dbg_data;

  shift_alu_datapath u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs(rs), .imm(imm), .done(done), .result(result),
    .zero(zero), .carry(carry), .out(out), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  // ---------------- wide instance ----------------
  logic           w_reset_n = 1'b0;
  logic           w_in_valid = 1'b0;
  logic           w_in_ready;
  logic [2:0]     w_opcode = 3'd0;
  logic [RW2-1:0] w_rd = '0;
  logic [RW2-1:0] w_rs = '0;
  logic [W2-1:0]  w_imm = '0;
  logic           w_done;
  logic [W2-1:0]  w_result;
  logic           w_zero;
  logic           w_carry;
  logic [W2-1:0]  w_out;
  logic [RW2-1:0] w_dbg_sel = '0;
  logic [W2-1:0]  w_dbg_data;

  shift_alu_datapath #(.WIDTH(W2), .NREG(N2)) u_dut_w (
    .clk(clk), .reset_n(w_reset_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .opcode(w_opcode), .rd(w_rd), .rs(w_rs), .imm(w_imm), .done(w_done),
    .result(w_result), .zero(w_zero), .carry(w_carry), .out(w_out),
    .dbg_sel(w_dbg_sel), .dbg_data(w_dbg_data)
  );

  // ---------------- reference model and scoreboard ----------------
  logic [W-1:0] m_reg [N];
  logic [W-1:0] m_res = '0;
  logic         m_zero = 1'b0;
  logic         m_carry = 1'b0;

  logic [W-1:0] exp_q[$];
  logic [1:0]   flag_q[$];
  int           cyc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_reg[i] = '0;
    m_res = '0;
    m_zero = 1'b0;
    m_carry = 1'b0;
    exp_q.delete();
    flag_q.delete();
    cyc_q.delete();
  endtask

  // Issue one instruction: wait for in_ready, predict its outcome, push the expectation.
  task automatic issue(input logic [2:0] op, input int d, input int s, input logic [W-1:0] im);
    int guard;
    int acc;
    int n;
    int e;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   v;
    logic           c;
    logic [2*W:0]   wide;
    logic [W:0]     sum;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("issue_ready_timeout", {31'd0, in_ready}, 32'd1);
    if (!in_ready) return;
    in_valid = 1'b1;
    opcode = op;
    rd = d[RW-1:0];
    rs = s[RW-1:0];
    imm = im;
    acc = cyc + 1;
    a = m_reg[d];
    b = m_reg[s];
    v = '0;
    c = 1'b0;
    e = 1;
    case (op)
      3'd0: v = im;
      3'd1: v = b;
      3'd2: v = a ^ b;
      3'd3: v = a & b;
      3'd4: begin
        sum = {1'b0, a} + {1'b0, b};
        v = sum[W-1:0];
        c = sum[W];
      end
      3'd5: begin
        v = W'(b * 2);
        c = b[W-1];
      end
      3'd6: begin
        n = (int'(im) > W) ? W : int'(im);
        wide = {{(W+1){1'b0}}, a} << n;
        v = wide[W-1:0];
        c = (n == 0) ? 1'b0 : wide[W];
        e = (n == 0) ? 1 : n;
      end
      default: ;
    endcase
    if (op != 3'd7) begin
      m_reg[d] = v;
      m_res = v;
      m_zero = (v == '0);
      m_carry = c;
    end
    exp_q.push_back(m_res);
    flag_q.push_back({m_zero, m_carry});
    cyc_q.push_back(acc + 1 + e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    opcode = 3'($urandom);
    rd = RW'($urandom);
    rs = RW'($urandom);
    imm = W'($urandom);
  endtask

  task automatic wait_done_ready(input string name);
    int guard;
    guard = 0;
    while (!done && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check({name, "_done_seen"}, {31'd0, done}, 32'd1);
    @(negedge clk);
    check({name, "_ready_after"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic check_regs(input string name);
    for (int i = 0; i < N; i++) begin
      dbg_sel = RW'(i);
      #1;
      check({name, "_reg"}, {24'd0, dbg_data}, {24'd0, m_reg[i]});
    end
    check({name, "_out"}, {24'd0, out}, {24'd0, m_reg[0]});
  endtask

  // Monitor: result compared in the done cycle, flags one cycle later.
  logic       prev_done = 1'b0;
  logic       pend = 1'b0;
  logic [1:0] pend_flags = 2'b00;
  always @(negedge clk) begin
    logic [W-1:0] e_v;
    int e_c;
    if (reset_n) begin
      if (pend) begin
        check("zero_flag", {31'd0, zero}, {31'd0, pend_flags[1]});
        check("carry_flag", {31'd0, carry}, {31'd0, pend_flags[0]});
      end
      pend = 1'b0;
      if (prev_done) check("done_consecutive", {31'd0, done}, 32'd0);
      if (done) begin
        check("unexpected_done", exp_q.size(), 32'd1 + exp_q.size() - ((exp_q.size() > 0) ? 32'd1 : 32'd0));
        if (exp_q.size() > 0) begin
          e_v = exp_q.pop_front();
          pend_flags = flag_q.pop_front();
          e_c = cyc_q.pop_front();
          pend = 1'b1;
          check("result", {24'd0, result}, {24'd0, e_v});
          check("done_cycle", e_c, cyc);
        end
      end
    end else begin
      pend = 1'b0;
    end
    prev_done = done;
  end

  initial begin
    int guard;
    int dones;
    model_reset();

    // Reset held two cycles with an LDI presented.
    in_valid = 1'b1;
    opcode = 3'd0;
    rd = 2'd1;
    imm = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
    end
    check_regs("rst");
    check("rst_result", {24'd0, result}, 32'd0);
    in_valid = 1'b0;
    reset_n = 1'b1;
    w_reset_n = 1'b1;
    #1;
    check("release_ready", {31'd0, in_ready}, 32'd1);

    // LDI / XOR
    issue(3'd0, 1, 0, 8'h3C); wait_done_ready("ldi1");
    issue(3'd0, 2, 0, 8'h0F); wait_done_ready("ldi2");
    issue(3'd2, 1, 2, 8'h00); wait_done_ready("xor");
    dbg_sel = 2'd1;
    #1;
    check("xor_r1", {24'd0, dbg_data}, 32'h33);

    // ADD overflow, then MOV clears carry
    issue(3'd0, 1, 0, 8'hF0); wait_done_ready("ldi3");
    issue(3'd0, 2, 0, 8'h10); wait_done_ready("ldi4");
    issue(3'd4, 1, 2, 8'h00); wait_done_ready("add");
    issue(3'd1, 0, 1, 8'h00); wait_done_ready("mov");
    check("mov_out", {24'd0, out}, 32'h00);
    check_regs("after_add");

    // SHLN: 3, saturating 9, and 0
    issue(3'd0, 3, 0, 8'h81); wait_done_ready("ldi5");
    issue(3'd6, 3, 0, 8'd3);  wait_done_ready("shln3");
    issue(3'd0, 3, 0, 8'h81); wait_done_ready("ldi6");
    issue(3'd6, 3, 0, 8'd9);  wait_done_ready("shln9");
    issue(3'd0, 3, 0, 8'h81); wait_done_ready("ldi7");
    issue(3'd6, 3, 0, 8'd0);  wait_done_ready("shln0");
    check_regs("after_shln");

    // Busy: LDI R2=0xAA presented during FETCH/EXEC must be ignored.
    issue(3'd6, 3, 0, 8'd3);
    @(negedge clk);
    in_valid = 1'b1;
    opcode = 3'd0;
    rd = 2'd2;
    imm = 8'hAA;
    guard = 0;
    while (!done && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    wait_done_ready("busy");
    check_regs("busy");

    // Abort: reset in the second EXEC cycle of an SHLN.
    issue(3'd6, 3, 0, 8'd5);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_regs("abort");
    check("abort_zero", {31'd0, zero}, 32'd0);
    check("abort_carry", {31'd0, carry}, 32'd0);
    check("abort_result", {24'd0, result}, 32'd0);
    reset_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_no_done", dones, 32'd0);

    // Randomized back-to-back traffic
    for (int k = 0; k < 60; k++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      issue(op, $urandom_range(0, N - 1), $urandom_range(0, N - 1),
            (op == 3'd6) ? W'($urandom_range(0, 12)) : W'($urandom));
    end
    guard = 0;
    while (exp_q.size() > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("drain_empty", exp_q.size(), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check_regs("random");

    // Wide instance: 16 bits, 8 registers
    for (int k = 0; k < 4; k++) begin
      logic [2:0] op;
      int dd;
      int ss;
      logic [W2-1:0] iv;
      case (k)
        0: begin op = 3'd0; dd = 7; ss = 0; iv = 16'hFFFF; end
        1: begin op = 3'd0; dd = 6; ss = 0; iv = 16'h0001; end
        2: begin op = 3'd4; dd = 7; ss = 6; iv = 16'h0000; end
        default: begin op = 3'd1; dd = 0; ss = 7; iv = 16'h0000; end
      endcase
      @(negedge clk);
      guard = 0;
      while (!w_in_ready && guard < 40) begin
        @(negedge clk);
        guard++;
      end
      w_in_valid = 1'b1;
      w_opcode = op;
      w_rd = RW2'(dd);
      w_rs = RW2'(ss);
      w_imm = iv;
      @(posedge clk);
      #1;
      w_in_valid = 1'b0;
      guard = 0;
      while (!w_done && guard < 40) begin
        @(negedge clk);
        guard++;
      end
      check("w_done_seen", {31'd0, w_done}, 32'd1);
      @(negedge clk);
      if (k == 2) begin
        w_dbg_sel = 3'd7;
        #1;
        check("w_add_r7", {16'd0, w_dbg_data}, 32'h0000);
        check("w_add_carry", {31'd0, w_carry}, 32'd1);
        check("w_add_zero", {31'd0, w_zero}, 32'd1);
      end
    end
    check("w_mov_out", {16'd0, w_out}, 32'h0000);
    w_dbg_sel = 3'd6;
    #1;
    check("w_dbg_r6", {16'd0, w_dbg_data}, 32'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shift_alu_datapath.md
# shift_alu_datapath

Parametrised multi-cycle register-file datapath: NREG registers of WIDTH bits, an operand (tmp) register, an ALU and a micro-sequencer. Each instruction is accepted over a valid/ready handshake. It is then executed in FETCH, EXEC and WRITEBACK states, and completion is signalled by a one-cycle `done` pulse. Over the previous fixed 8-bit, 4-register datapath it adds parametrised width and depth, ADD with carry, zero/carry flags, a multi-cycle variable shift, and reset. R0 stays the primary output.

## Interface
- WIDTH, default 8: data width, ≥4.
- NREG, default 4: register count, a power of 2, ≥2.
- RW, derived $clog2(NREG): register index width; not overridable.
- clk  input  1  rising-edge clock, sole clock.
- reset_n  input  1  synchronous, active-low reset.
- in_valid  input  1  instruction present.
- in_ready  output  1  block accepts an instruction this cycle.
- opcode  input  3  operation, sampled at accept.
- rd  input  RW  destination register, also operand A.
- rs  input  RW  source register, operand B.
- imm  input  WIDTH  immediate (LDI value, or SHLN amount).
- done  output  1  one-cycle pulse in the WRITEBACK cycle.
- result  output  WIDTH  value being written; held until the next WRITEBACK.
- zero  output  1  result==0 flag of the last completed op.
- carry  output  1  carry flag of the last completed op.
- out  output  WIDTH  R0, always.
- dbg_sel  input  RW  debug read index.
- dbg_data  output  WIDTH  R[dbg_sel], combinational.

## Operation
- Opcodes:
  - 000 LDI: rd ← imm.
  - 001 MOV: rd ← R[rs].
  - 010 XOR: rd ← R[rd]^R[rs].
  - 011 AND: rd ← R[rd]&R[rs].
  - 100 ADD: rd ← (R[rd]+R[rs]) mod 2^WIDTH; carry = bit WIDTH of the sum.
  - 101 SHL: rd ← R[rs]<<1; carry = R[rs][WIDTH-1].
  - 110 SHLN: rd ← R[rd]<<n, one bit per cycle, with n = min(imm, WIDTH); carry = last bit shifted out, 0 if n=0.
  - 111 NOP: no register write; done still pulses; flags unchanged.
- Carry is cleared by LDI, MOV, XOR and AND.
- Zero = (written value == 0). It is updated on every op except NOP.
- Accept: an instruction is accepted when in_valid && in_ready is high at a rising edge. The opcode, rd, rs and imm fields are captured into internal registers. Input changes after acceptance have no effect.
- States: IDLE → FETCH → EXEC → WB → IDLE.
  - IDLE: in_ready=1 (0 while reset_n is low).
  - FETCH: tmp ← R[rd], b ← R[rs]. The shift counter is loaded with n.
  - EXEC: one cycle for every op except SHLN. For SHLN, EXEC lasts max(n,1) cycles, with tmp ← tmp<<1 each cycle while the counter is nonzero.
  - WB: write R[rd] (unless NOP), update the flags, done=1, result driven. Return to IDLE.
- rd==rs is legal. Both operands are read in FETCH.
- in_valid is ignored outside IDLE; no queuing. Only the WB state writes registers.
- dbg_data and out reflect register contents after the WB edge.

## Timing
- Let accept occur at edge T. Then:
  - FETCH runs in cycle T+1.
  - EXEC runs in cycles T+2 … T+1+E, where E = 1, or max(n,1) for SHLN.
  - WB runs in cycle T+2+E; done is high there.
  - The new register value and flags are visible from cycle T+3+E.
  - in_ready is high again in cycle T+3+E.
- Non-SHLN ops therefore occupy 4 cycles, including the IDLE cycle. Back-to-back throughput is one instruction per 4 cycles.
- Reset: reset_n low at an edge forces:
  - all R[i]=0, tmp=0, result=0, zero=0, carry=0;
  - state IDLE, done=0.
- in_ready is 0 while reset_n is low. It is 1 in the first cycle after release.
- Reset during FETCH, EXEC or WB aborts the op with no register or flag write. If reset and WB coincide at the same edge, reset wins and no write occurs.
- done never asserts for two consecutive cycles.

## Test plan
- **Reset:** hold reset_n=0 for 2 cycles with in_valid=1, opcode=LDI. Required: in_ready=0, done=0, every register 0. In the first cycle after release, in_ready=1.
- **LDI and XOR:**
  - LDI R1=0x3C, then LDI R2=0x0F, then XOR rd=1, rs=2.
  - Required: R1=0x33, zero=0, carry=0.
  - done is asserted exactly 3 cycles after each accept, and in_ready returns 1 cycle later.
- **ADD overflow:** R1=0xF0, R2=0x10, ADD rd=1, rs=2. Required: R1=0x00, zero=1, carry=1. Follow with MOV rd=0, rs=1: out=0x00 and carry=0.
- **SHLN:**
  - R3=0x81, SHLN rd=3, imm=3: R3=0x08, carry=0, done at T+5.
  - Then R3=0x81, SHLN imm=9: R3=0x00, zero=1, carry=1, 8 EXEC cycles, done at T+10.
  - Then SHLN imm=0: value unchanged, carry=0, done at T+3.
- **Busy and abort:**
  - Drive in_valid with LDI R2=0xAA during FETCH/EXEC of a prior op. Required: ignored, R2 unchanged.
  - Assert reset_n=0 in the 2nd EXEC cycle of an SHLN. Required: no done pulse, all registers 0.
- **Parametrisation:** run with WIDTH=16, NREG=8.
  - LDI R7=0xFFFF, LDI R6=0x0001, ADD rd=7, rs=6. Required: R7=0x0000, carry=1.
  - Then MOV rd=0, rs=7. Required: out=0x0000.
  - dbg_sel=6 reads 0x0001.
